uart_mem_arbiter: RTL
=====================

// Module: uart_mem_arbiter
// PURPOSE
//  Shares the single UART-backed memory port (uart_ram) between the CPU instruction-fetch (I) and data (D) requesters.
//  Registers the winning request, holds it stable for the whole UART transaction, and routes ready/rd_data back to the winner.
//  Sits between the core's split I/D buses and uart_ram in the top level.
// PARAMETERS
//  MaxConsecD  4  D grants in a row while I is waiting before I is forced to win the next grant (1..15)
// PORTS
//  clk_i         in   1   clock
//  reset_ni      in   1   asynchronous reset, active low
//  i_valid_i     in   1   I request; read only, held until i_ready_o
//  i_addr_i      in   32  I address
//  i_ready_o     out  1   one-cycle completion pulse to I
//  i_rdata_o     out  32  I read data; valid while i_ready_o=1
//  d_valid_i     in   1   D request; held until d_ready_o
//  d_wstrb_i     in   4   0000=read, else byte-lane write strobes
//  d_addr_i      in   32  D address
//  d_wdata_i     in   32  D write data
//  d_ready_o     out  1   one-cycle completion pulse to D
//  d_rdata_o     out  32  D read data; valid while d_ready_o=1
//  mem_valid_o   out  1   to uart_ram mem_valid_i
//  mem_wstrb_o   out  4   to uart_ram mem_wstrb_i
//  mem_addr_o    out  32  to uart_ram addr_i
//  mem_wdata_o   out  32  to uart_ram wr_data_i
//  mem_rdata_i   in   32  from uart_ram rd_data_o
//  mem_ready_i   in   1   from uart_ram ready_o; one-cycle pulse
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; state Idle; consecutive-D counter 0; grant register 0 (I).
//  - FSM: Idle -> Issue -> Done -> Idle. With UART_ARB_IBUF_EN, also Idle -> Hit -> Done.
//  - Idle:
//    - Arbitrate on *_valid_i. Only one valid: it wins.
//    - Both valid: D wins unless the D counter == MaxConsecD; then I wins.
//    - Capture wstrb (0 for I), addr and wdata into the mem_* registers; record the grant; go to Issue.
//  - Issue:
//    - mem_valid_o=1; mem_wstrb_o, mem_addr_o and mem_wdata_o stay constant until mem_ready_i.
//    - Winner's *_valid_i is ignored after capture.
//  - Completion:
//    - On mem_ready_i in Issue, drive ready = mem_ready_i & grant for the winner in that same cycle (combinational).
//    - Winner's rdata = mem_rdata_i; the loser's ready and rdata stay 0. Go to Done.
//  - Done:
//    - One idle cycle: mem_valid_o=0 so uart_ram re-enters its Idle and the requester can drop valid.
//    - Then Idle. Minimum request spacing is 3 cycles.
//  - D counter:
//    - +1 on a D grant while i_valid_i=1; saturates at MaxConsecD.
//    - Cleared on any I grant, and on a D grant while i_valid_i=0.
//  - mem_ready_i outside Issue is ignored: no ready is emitted.
//  - Back-to-back request from the same requester in Done is not accepted until Idle.
//  - Reset mid-transaction aborts immediately.
// CONFIGURATION
//  - UART_ARB_IBUF_EN defined: one-entry fetch buffer {vld, addr[31:2], data}.
//    - Loaded when an I read completes.
//    - In Idle, an I-only or I-wins request whose addr[31:2] matches a valid entry goes to Hit:
//      no mem_valid_o; i_ready_o=1 and i_rdata_o=buffered data in Hit; then Done.
//    - vld cleared at reset and on a D write grant (wstrb!=0) with matching addr[31:2].
//  - UART_ARB_IBUF_EN undefined: no buffer; every I request goes to Issue.
// TESTING
//  - I read 0x0000_0010, mem_ready_i 5 cyc after mem_valid_o with rdata 0xDEAD_BEEF
//    -> mem_addr_o=0x10, mem_wstrb_o=0; i_ready_o pulses 1 cycle with 0xDEAD_BEEF; d_ready_o stays 0.
//  - D write addr 0x100, wstrb 0011, data 0x1234_5678
//    -> mem_* match and stay constant until mem_ready_i; d_ready_o single pulse; mem_valid_o low in Done.
//  - I and D held valid continuously, MaxConsecD=4
//    -> grant order D,D,D,D,I,D,D,D,D,I...
//  - mem_ready_i pulse injected in Idle or Done -> no i_ready_o or d_ready_o.
//  - reset_ni low mid-Issue -> all outputs 0 immediately; after release a new I read completes normally.
//  - IBUF_EN: I read 0x20 twice -> second completes with no mem_valid_o.
//    D write to 0x20 in between -> second read goes to UART.

Source files
------------

// File: rtl/uart_mem_arbiter.sv
// uart_mem_arbiter: shares the single uart_ram port between the I-fetch and D requesters.
// Registers the winning request, holds it stable for the whole UART transaction and
// routes ready/rdata back to the winner. D wins ties until MaxConsecD consecutive D
// grants have starved a waiting I request; then I is forced through.
// Optional feature: define UART_ARB_IBUF_EN for a one-entry instruction fetch buffer.
module uart_mem_arbiter #(
  parameter int unsigned MaxConsecD = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        i_valid_i,
  input  logic [31:0] i_addr_i,
  output logic        i_ready_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_valid_i,
  input  logic [3:0]  d_wstrb_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ready_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_valid_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int unsigned CntW = 4;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StHit   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            grant_q, grant_d;  // 0 = I, 1 = D
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_valid_q, mem_valid_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;

  logic cnt_sat, i_win, d_win, done_c;

`ifdef UART_ARB_IBUF_EN
  logic        ibuf_vld_q, ibuf_vld_d;
  logic [29:0] ibuf_tag_q, ibuf_tag_d;
  logic [31:0] ibuf_data_q, ibuf_data_d;
  logic        ibuf_hit_c;

  assign ibuf_hit_c = ibuf_vld_q && (ibuf_tag_q == i_addr_i[31:2]);
`endif

  // Arbitration: D normally wins a tie, I is forced after MaxConsecD D grants
  assign cnt_sat = (cnt_q == CntW'(MaxConsecD));
  assign i_win   = i_valid_i & (~d_valid_i | cnt_sat);
  assign d_win   = d_valid_i & ~i_win;
  assign done_c  = (state_q == StIssue) & mem_ready_i;

  // Next-state and request capture
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef UART_ARB_IBUF_EN
    ibuf_vld_d  = ibuf_vld_q;
    ibuf_tag_d  = ibuf_tag_q;
    ibuf_data_d = ibuf_data_q;
`endif
    case (state_q)
      StIdle: begin
        if (i_win) begin
          grant_d = 1'b0;
          cnt_d   = '0;
`ifdef UART_ARB_IBUF_EN
          if (ibuf_hit_c) begin
            state_d = StHit;
          end else begin
            state_d     = StIssue;
            mem_valid_d = 1'b1;
            mem_wstrb_d = 4'b0000;
            mem_addr_d  = i_addr_i;
            mem_wdata_d = '0;
          end
`else
          state_d     = StIssue;
          mem_valid_d = 1'b1;
          mem_wstrb_d = 4'b0000;
          mem_addr_d  = i_addr_i;
          mem_wdata_d = '0;
`endif
        end else if (d_win) begin
          grant_d     = 1'b1;
          state_d     = StIssue;
          mem_valid_d = 1'b1;
          mem_wstrb_d = d_wstrb_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          if (!i_valid_i)   cnt_d = '0;
          else if (!cnt_sat) cnt_d = cnt_q + CntW'(1);
`ifdef UART_ARB_IBUF_EN
          if ((d_wstrb_i != 4'b0000) && (ibuf_tag_q == d_addr_i[31:2])) ibuf_vld_d = 1'b0;
`endif
        end
      end
      StIssue: begin
        if (mem_ready_i) begin
          state_d     = StDone;
          mem_valid_d = 1'b0;
`ifdef UART_ARB_IBUF_EN
          if (!grant_q) begin
            ibuf_vld_d  = 1'b1;
            ibuf_tag_d  = mem_addr_q[31:2];
            ibuf_data_d = mem_rdata_i;
          end
`endif
        end
      end
      StDone:  state_d = StIdle;
      StHit:   state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // State and request registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef UART_ARB_IBUF_EN
      ibuf_vld_q  <= 1'b0;
      ibuf_tag_q  <= '0;
      ibuf_data_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef UART_ARB_IBUF_EN
      ibuf_vld_q  <= ibuf_vld_d;
      ibuf_tag_q  <= ibuf_tag_d;
      ibuf_data_q <= ibuf_data_d;
`endif
    end
  end

  // Completion is routed to the winner in the same cycle as mem_ready_i
  assign i_ready_o = (done_c & ~grant_q) | (state_q == StHit);
  assign d_ready_o = done_c & grant_q;
`ifdef UART_ARB_IBUF_EN
  assign i_rdata_o = (state_q == StHit) ? ibuf_data_q :
                     ((done_c & ~grant_q) ? mem_rdata_i : '0);
`else
  assign i_rdata_o = (done_c & ~grant_q) ? mem_rdata_i : '0;
`endif
  assign d_rdata_o = (done_c & grant_q) ? mem_rdata_i : '0;

  assign mem_valid_o = mem_valid_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
